lcd_instruction_tx: RTL

Physical-layer transmitter for the character LCD's 4-bit interface. It accepts one 10-bit instruction word per `next_instruction` pulse from the configuration/update FSM and splits it into upper and lower nibbles on the data pins. Each nibble gets its own enable strobe, with the required setup, pulse-width, hold, inter-nibble and post-command delays. When the whole sequence is finished it returns a single-cycle `done`. It sits between the configuration FSM and the top-level LCD pins.

---
 rtl/lcd_instruction_tx.sv | 79 +++++++
 1 files changed

// File: rtl/lcd_instruction_tx.sv
// lcd_instruction_tx: sends one 10-bit LCD instruction as two timed 4-bit nibbles and pulses done when finished
module lcd_instruction_tx #(
  parameter int T_SETUP = 2,
  parameter int T_E     = 12,
  parameter int T_HOLD  = 1,
  parameter int T_GAP   = 50,
  parameter int T_WAIT  = 2000,
  parameter int CNT_W   = 11
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       next_instruction_i,
  input  logic [9:0] db_i,
  output logic       done_o,
  output logic       busy_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [3:0] sf_d_o
);
  typedef enum logic [3:0] {
    IDLE, LATCH, U_SETUP, U_E, U_HOLD, GAP, L_SETUP, L_E, L_HOLD, WAIT, DONE
  } state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, last;
  logic [9:0] word_q, word_d;
  logic tick, timed, upper, lower;
  always_comb begin
    last = (state_q == U_SETUP || state_q == L_SETUP) ? CNT_W'(T_SETUP - 1) :
           (state_q == U_E || state_q == L_E)         ? CNT_W'(T_E - 1) :
           (state_q == U_HOLD || state_q == L_HOLD)   ? CNT_W'(T_HOLD - 1) :
           (state_q == GAP)                           ? CNT_W'(T_GAP - 1) :
                                                        CNT_W'(T_WAIT - 1);
    tick = cnt_q == last;
    timed = state_q inside {U_SETUP, U_E, U_HOLD, GAP, L_SETUP, L_E, L_HOLD, WAIT};
    cnt_d = (timed && !tick) ? cnt_q + CNT_W'(1) : '0;
    word_d = (state_q == LATCH) ? db_i : word_q;
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = next_instruction_i ? LATCH : IDLE;
      LATCH:   state_d = U_SETUP;
      U_SETUP: state_d = tick ? U_E : U_SETUP;
      U_E:     state_d = tick ? U_HOLD : U_E;
      U_HOLD:  state_d = tick ? GAP : U_HOLD;
      GAP:     state_d = tick ? L_SETUP : GAP;
      L_SETUP: state_d = tick ? L_E : L_SETUP;
      L_E:     state_d = tick ? L_HOLD : L_E;
      L_HOLD:  state_d = tick ? WAIT : L_HOLD;
      WAIT:    state_d = tick ? DONE : WAIT;
      default: state_d = IDLE;
    endcase
    upper = state_d inside {U_SETUP, U_E, U_HOLD, GAP};
    lower = state_d inside {L_SETUP, L_E, L_HOLD, WAIT, DONE};
  end
  // outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      done_o   <= 1'b0;
      busy_o   <= 1'b0;
      lcd_e_o  <= 1'b0;
      lcd_rs_o <= 1'b0;
      lcd_rw_o <= 1'b0;
      sf_d_o   <= 4'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      done_o   <= state_d == DONE;
      busy_o   <= state_d != IDLE;
      lcd_e_o  <= state_d inside {U_E, L_E};
      lcd_rs_o <= (upper || lower) && word_d[9];
      lcd_rw_o <= (upper || lower) && word_d[8];
      sf_d_o   <= upper ? word_d[7:4] : lower ? word_d[3:0] : sf_d_o;
    end
  end
endmodule
